div_arb: RTL and testbench

DIV_ARB -- requirements
Module: div_arb

---
 rtl/div_arb_pkg.sv | 18 +
 rtl/div_arb_if.sv | 35 +++
 rtl/div_arb_rr_arb2.sv | 32 +++
 rtl/div_arb.sv | 147 ++++++++++++++
 tb/tb_div_arb.sv | 269 ++++++++++++++++++++++++++
 5 files changed

// File: rtl/div_arb_pkg.sv
// div_pkg: shared definitions for the divider arbiter.
// Holds the controller state encoding, the default divider latency and the
// result that is reported instead of a real division when the divisor is zero.
package div_pkg;

  localparam int DIV_LAT_DEF = 10;

  localparam logic [7:0] DZ_ANS = 8'hFF;
  localparam logic [3:0] DZ_ARE = 4'hF;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_LOAD = 2'd1,
    S_BUSY = 2'd2,
    S_CAP  = 2'd3
  } state_t;

endpackage

// File: rtl/div_arb_if.sv
// div_arb_if: bundle of the requester handshakes, the result bus and the
// shared-divider connection.
//   req0/req1, dd0/dd1, dq0/dq1 : requests and operands (requester -> arbiter)
//   gnt0/gnt1, done0/done1      : one-cycle grant / completion pulses
//   ans, are, err               : result of the last completed operation
//   div_dd, div_dq, div_start   : operands and start pulse to the divider
//   div_ans, div_are            : divider quotient / remainder
// slave is the arbiter side, master the requester/divider side.
interface div_arb_if;

  logic       req0, req1;
  logic [7:0] dd0, dd1;
  logic [3:0] dq0, dq1;
  logic       gnt0, gnt1;
  logic       done0, done1;
  logic [7:0] ans;
  logic [3:0] are;
  logic       err;
  logic [7:0] div_dd;
  logic [3:0] div_dq;
  logic       div_start;
  logic [7:0] div_ans;
  logic [3:0] div_are;

  modport slave (
    input  req0, req1, dd0, dd1, dq0, dq1, div_ans, div_are,
    output gnt0, gnt1, done0, done1, ans, are, err, div_dd, div_dq, div_start
  );

  modport master (
    output req0, req1, dd0, dd1, dq0, dq1, div_ans, div_are,
    input  gnt0, gnt1, done0, done1, ans, are, err, div_dd, div_dq, div_start
  );

endinterface

// File: rtl/div_arb_rr_arb2.sv
// rr_arb2: two-input round-robin arbiter.
//   clk, rst : clock, asynchronous active-high reset
//   req      : request vector {req1, req0}
//   accept   : the current winner has been granted; remember it
//   valid    : at least one request is pending
//   idx      : index of the winning requester
// The pointer holds the last granted index; it resets to 1 so that
// requester 0 wins the first tie.
module rr_arb2 (
  input  logic       clk,
  input  logic       rst,
  input  logic [1:0] req,
  input  logic       accept,
  output logic       valid,
  output logic       idx
);

  logic last;

  assign valid = |req;
  // On a tie the requester not granted last wins; otherwise the lone one.
  assign idx   = (req == 2'b11) ? ~last : req[1];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      last <= 1'b1;
    end else if (accept) begin
      last <= idx;
    end
  end

endmodule

// File: rtl/div_arb.sv
// div_arb: shares one multi-cycle divider between two requesters.
//   clk : clock, all state changes on the rising edge
//   rst : asynchronous active-high reset
//   bus : div_arb_if.slave (requests, grants, results, divider port)
// Parameter DIV_LAT: cycles the divider needs after div_start before its
// outputs are valid.
//
// state  | meaning
// IDLE   | waiting for a request; arbitrates and latches operands
// LOAD   | operands on div_dd/div_dq; start divider (or skip on divisor 0)
// BUSY   | counting down the divider latency
// CAP    | capture result (or divide-by-zero constants), pulse done
module div_arb
  import div_pkg::*;
#(
  parameter int DIV_LAT = DIV_LAT_DEF
) (
  input logic     clk,
  input logic     rst,
  div_arb_if.slave bus
);

  localparam int CNT_W = (DIV_LAT > 1) ? $clog2(DIV_LAT) : 1;
  localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(DIV_LAT - 1);

  state_t           state, state_nxt;
  logic [CNT_W-1:0] cnt, cnt_nxt;
  logic             sel, sel_nxt;
  logic [1:0]       gnt, gnt_nxt;
  logic [1:0]       done, done_nxt;
  logic             div_start, div_start_nxt;
  logic [7:0]       ans, ans_nxt;
  logic [3:0]       are, are_nxt;
  logic             err, err_nxt;
  logic [7:0]       div_dd, div_dd_nxt;
  logic [3:0]       div_dq, div_dq_nxt;

  logic arb_valid, arb_idx, arb_accept;

  rr_arb2 u_arb (
    .clk    (clk),
    .rst    (rst),
    .req    ({bus.req1, bus.req0}),
    .accept (arb_accept),
    .valid  (arb_valid),
    .idx    (arb_idx)
  );

  always_comb begin
    state_nxt     = state;
    cnt_nxt       = cnt;
    sel_nxt       = sel;
    gnt_nxt       = 2'b00;
    done_nxt      = 2'b00;
    div_start_nxt = 1'b0;
    ans_nxt       = ans;
    are_nxt       = are;
    err_nxt       = err;
    div_dd_nxt    = div_dd;
    div_dq_nxt    = div_dq;
    arb_accept    = 1'b0;

    case (state)
      S_IDLE: begin
        if (arb_valid) begin
          arb_accept = 1'b1;
          sel_nxt    = arb_idx;
          gnt_nxt    = arb_idx ? 2'b10 : 2'b01;
          div_dd_nxt = arb_idx ? bus.dd1 : bus.dd0;
          div_dq_nxt = arb_idx ? bus.dq1 : bus.dq0;
          state_nxt  = S_LOAD;
        end
      end
      S_LOAD: begin
        // A zero divisor never reaches the divider.
        if (div_dq == 4'd0) begin
          state_nxt = S_CAP;
        end else begin
          div_start_nxt = 1'b1;
          cnt_nxt       = CNT_LOAD;
          state_nxt     = S_BUSY;
        end
      end
      S_BUSY: begin
        if (cnt == '0) begin
          state_nxt = S_CAP;
        end else begin
          cnt_nxt = cnt - CNT_W'(1);
        end
      end
      S_CAP: begin
        if (div_dq == 4'd0) begin
          ans_nxt = DZ_ANS;
          are_nxt = DZ_ARE;
          err_nxt = 1'b1;
        end else begin
          ans_nxt = bus.div_ans;
          are_nxt = bus.div_are;
          err_nxt = 1'b0;
        end
        done_nxt  = sel ? 2'b10 : 2'b01;
        state_nxt = S_IDLE;
      end
      default: state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= S_IDLE;
      cnt       <= '0;
      sel       <= 1'b0;
      gnt       <= 2'b00;
      done      <= 2'b00;
      div_start <= 1'b0;
      ans       <= 8'd0;
      are       <= 4'd0;
      err       <= 1'b0;
      div_dd    <= 8'd0;
      div_dq    <= 4'd0;
    end else begin
      state     <= state_nxt;
      cnt       <= cnt_nxt;
      sel       <= sel_nxt;
      gnt       <= gnt_nxt;
      done      <= done_nxt;
      div_start <= div_start_nxt;
      ans       <= ans_nxt;
      are       <= are_nxt;
      err       <= err_nxt;
      div_dd    <= div_dd_nxt;
      div_dq    <= div_dq_nxt;
    end
  end

  assign bus.gnt0      = gnt[0];
  assign bus.gnt1      = gnt[1];
  assign bus.done0     = done[0];
  assign bus.done1     = done[1];
  assign bus.div_start = div_start;
  assign bus.ans       = ans;
  assign bus.are       = are;
  assign bus.err       = err;
  assign bus.div_dd    = div_dd;
  assign bus.div_dq    = div_dq;

endmodule

// File: tb/tb_div_arb.sv
// tb_div_arb: bench for div_arb with a latency-accurate divider model, a
// timeline-based reference model and directed plus random requesters.
module tb_div_arb;
  import div_pkg::*;

  localparam int LAT  = 10;
  localparam int MAXC = 8192;

  logic clk = 1'b0;
  logic rst = 1'b1;

  div_arb_if bus();

  div_arb #(.DIV_LAT(LAT)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  always #5 clk = ~clk;

  int tests = 0;
  int fails = 0;
  int cyc   = -1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s cyc=%0d actual=%0h required=%0h", name, cyc, act, exp);
    end
  endtask

  // Divider: garbage until LAT cycles after the start pulse, then q/r.
  logic [7:0] dv_ans = 8'd0, dv_q = 8'd0, tq, tr;
  logic [3:0] dv_are = 4'd0, dv_r = 4'd0;
  int dv_p = 0;
  int n_start = 0;

  always @(posedge clk) begin
    if (bus.div_start === 1'b1) begin
      n_start++;
      tq = (bus.div_dq != 4'd0) ? bus.div_dd / {4'd0, bus.div_dq} : 8'd0;
      tr = (bus.div_dq != 4'd0) ? bus.div_dd % {4'd0, bus.div_dq} : 8'd0;
      dv_q   <= tq;
      dv_r   <= tr[3:0];
      dv_ans <= ~tq;
      dv_are <= ~tr[3:0];
      dv_p   <= LAT - 1;
    end else if (dv_p > 0) begin
      dv_p <= dv_p - 1;
      if (dv_p == 1) begin
        dv_ans <= dv_q;
        dv_are <= dv_r;
      end
    end
  end

  assign bus.div_ans = dv_ans;
  assign bus.div_are = dv_are;

  // Reference model: a grant decided at edge k fixes the whole timeline of
  // the operation (gnt after k, start after k+1, done after k+2 or k+2+LAT).
  bit   [1:0] e_gnt  [MAXC];
  bit   [1:0] e_done [MAXC];
  bit         e_start[MAXC];
  bit         e_res  [MAXC];
  bit         e_chk  [MAXC];
  bit         e_err  [MAXC];
  logic [7:0] e_ans  [MAXC];
  logic [3:0] e_are  [MAXC];
  logic [7:0] e_dd   [MAXC];
  logic [3:0] e_dq   [MAXC];
  int free_edge = 0;
  int last_w    = 1;
  int m_w, m_dn;
  logic [7:0] m_dd;
  logic [3:0] m_dq;

  always @(posedge clk) begin
    cyc = cyc + 1;
    if (rst) begin
      for (int c = cyc; c < cyc + LAT + 8; c++) begin
        if (c < MAXC) begin
          e_gnt[c] = 0; e_done[c] = 0; e_start[c] = 0; e_res[c] = 0; e_chk[c] = 0;
        end
      end
      free_edge = cyc + 1;
      last_w    = 1;
    end else if (cyc >= free_edge && (bus.req0 === 1'b1 || bus.req1 === 1'b1)
                 && cyc + LAT + 4 < MAXC) begin
      if (bus.req0 === 1'b1 && bus.req1 === 1'b1) m_w = 1 - last_w;
      else m_w = (bus.req1 === 1'b1) ? 1 : 0;
      last_w = m_w;
      m_dd = m_w ? bus.dd1 : bus.dd0;
      m_dq = m_w ? bus.dq1 : bus.dq0;
      m_dn = (m_dq == 4'd0) ? cyc + 2 : cyc + 2 + LAT;
      e_gnt[cyc] = (m_w == 1) ? 2'b10 : 2'b01;
      if (m_dq != 4'd0) e_start[cyc + 1] = 1;
      e_done[m_dn] = (m_w == 1) ? 2'b10 : 2'b01;
      e_res[m_dn]  = 1;
      e_err[m_dn]  = (m_dq == 4'd0);
      e_ans[m_dn]  = (m_dq == 4'd0) ? 8'hFF : 8'(m_dd / m_dq);
      e_are[m_dn]  = (m_dq == 4'd0) ? 4'hF  : 4'(m_dd % m_dq);
      for (int c = cyc; c <= m_dn; c++) begin
        e_chk[c] = 1; e_dd[c] = m_dd; e_dq[c] = m_dq;
      end
      free_edge = m_dn + 1;
    end
  end

  logic [7:0] h_ans = 8'd0;
  logic [3:0] h_are = 4'd0;
  logic       h_err = 1'b0;

  always @(posedge clk) begin
    #1;
    if (cyc >= 0 && cyc < MAXC) begin
      if (rst) begin
        h_ans = 8'd0; h_are = 4'd0; h_err = 1'b0;
      end else if (e_res[cyc]) begin
        h_ans = e_ans[cyc]; h_are = e_are[cyc]; h_err = e_err[cyc];
      end
      check("gnt",       {bus.gnt1, bus.gnt0},   rst ? 2'b00 : e_gnt[cyc]);
      check("done",      {bus.done1, bus.done0}, rst ? 2'b00 : e_done[cyc]);
      check("div_start", bus.div_start,          rst ? 1'b0 : e_start[cyc]);
      check("ans", bus.ans, h_ans);
      check("are", bus.are, h_are);
      check("err", bus.err, h_err);
      if (rst) begin
        check("rst_div_dd", bus.div_dd, 8'd0);
        check("rst_div_dq", bus.div_dq, 4'd0);
      end else if (e_chk[cyc]) begin
        check("div_dd", bus.div_dd, e_dd[cyc]);
        check("div_dq", bus.div_dq, e_dq[cyc]);
      end
    end
  end

  task automatic wait_any(output int who, output int dc);
    who = -1; dc = -1;
    for (int n = 0; n < 40; n++) begin
      @(posedge clk); #2;
      if (bus.done0 === 1'b1 || bus.done1 === 1'b1) begin
        who = (bus.done1 === 1'b1) ? 1 : 0;
        dc  = cyc;
        break;
      end
    end
    if (dc < 0) check("done_timeout", 0, 1);
  endtask

  task automatic wait_done(input int idx, output int dc);
    int who;
    wait_any(who, dc);
    check("done_who", who, idx);
  endtask

  int k, dc, dc0, dc1, who, st0;
  logic [1:0] rq;
  bit   [1:0] pend, gseen;
  logic [7:0] rdd [2];
  logic [3:0] rdq [2];
  logic       dn;

  initial begin
    bus.req0 = 0; bus.req1 = 0;
    bus.dd0 = 0; bus.dd1 = 0; bus.dq0 = 0; bus.dq1 = 0;
    repeat (2) @(negedge clk);
    check("rst_ans", bus.ans, 0);
    check("rst_err", bus.err, 0);
    check("rst_div_dd0", bus.div_dd, 0);
    rst = 0;

    // Tie from reset: 0, then 1, then 0 again on the next tie.
    @(negedge clk);
    bus.req0 = 1; bus.dd0 = 8'd20; bus.dq0 = 4'd3;
    bus.req1 = 1; bus.dd1 = 8'd90; bus.dq1 = 4'd9;
    wait_any(who, dc); bus.req0 = 0;
    check("tie1_who", who, 0); check("tie1_ans", bus.ans, 6); check("tie1_are", bus.are, 2);
    wait_any(who, dc); bus.req1 = 0;
    check("tie2_who", who, 1); check("tie2_ans", bus.ans, 10); check("tie2_are", bus.are, 0);
    @(negedge clk);
    bus.req0 = 1; bus.dd0 = 8'd50; bus.dq0 = 4'd4;
    bus.req1 = 1; bus.dd1 = 8'd9;  bus.dq1 = 4'd2;
    wait_any(who, dc); bus.req0 = 0;
    check("tie3_who", who, 0); check("tie3_ans", bus.ans, 12);
    wait_any(who, dc); bus.req1 = 0;
    check("tie4_who", who, 1); check("tie4_ans", bus.ans, 4); check("tie4_are", bus.are, 1);

    // Single operation 100/7.
    @(negedge clk);
    bus.req0 = 1; bus.dd0 = 8'd100; bus.dq0 = 4'd7; k = cyc + 1; st0 = n_start;
    wait_done(0, dc); bus.req0 = 0;
    check("single_lat", dc - k, 12);
    check("single_ans", bus.ans, 14); check("single_are", bus.are, 2); check("single_err", bus.err, 0);
    repeat (3) @(negedge clk);
    check("single_starts", n_start - st0, 1);

    // Divisor zero.
    bus.req1 = 1; bus.dd1 = 8'd55; bus.dq1 = 4'd0; k = cyc + 1; st0 = n_start;
    wait_done(1, dc); bus.req1 = 0;
    check("dz_lat", dc - k, 2);
    check("dz_ans", bus.ans, 8'hFF); check("dz_are", bus.are, 4'hF); check("dz_err", bus.err, 1);
    repeat (3) @(negedge clk);
    check("dz_starts", n_start - st0, 0);

    // Reset during BUSY.
    bus.req0 = 1; bus.dd0 = 8'd123; bus.dq0 = 4'd10; k = cyc + 1;
    while (cyc < k + 6) @(posedge clk);
    #2 rst = 1;
    #1;
    check("rb_ans", bus.ans, 0); check("rb_are", bus.are, 0); check("rb_err", bus.err, 0);
    check("rb_dd", bus.div_dd, 0); check("rb_start", bus.div_start, 0);
    repeat (2) @(negedge clk);
    rst = 0; k = cyc + 1; st0 = n_start;
    wait_done(0, dc); bus.req0 = 0;
    check("rb_lat", dc - k, 12); check("rb_ans2", bus.ans, 12); check("rb_are2", bus.are, 3);
    check("rb_starts", n_start - st0, 1);

    // Late request during requester 0's operation.
    @(negedge clk);
    bus.req0 = 1; bus.dd0 = 8'd200; bus.dq0 = 4'd6; k = cyc + 1;
    while (cyc < k + 5) @(negedge clk);
    bus.req1 = 1; bus.dd1 = 8'd77; bus.dq1 = 4'd5;
    bus.dd0 = 8'd3; bus.dq0 = 4'd1;
    repeat (2) @(negedge clk);
    check("late_dd_hold", bus.div_dd, 200); check("late_dq_hold", bus.div_dq, 6);
    wait_done(0, dc0); bus.req0 = 0;
    check("late_ans0", bus.ans, 33); check("late_are0", bus.are, 2);
    wait_done(1, dc1); bus.req1 = 0;
    check("late_gap", dc1 - dc0, 13);
    check("late_ans1", bus.ans, 15); check("late_are1", bus.are, 2);

    // Random requesters with occasional mid-op drops and resets.
    rq = 2'b00; pend = 2'b00; gseen = 2'b00;
    rdd[0] = 0; rdd[1] = 0; rdq[0] = 0; rdq[1] = 0;
    for (int i = 0; i < 1500; i++) begin
      @(negedge clk);
      if (rst) begin
        rst = 0;
      end else if ($urandom_range(0, 299) == 0) begin
        rst = 1; rq = 2'b00; pend = 2'b00;
      end else begin
        for (int n = 0; n < 2; n++) begin
          dn = n ? bus.done1 : bus.done0;
          if ((n ? bus.gnt1 : bus.gnt0) === 1'b1) gseen[n] = 1;
          if (pend[n] && dn === 1'b1) begin
            rq[n] = 0; pend[n] = 0;
          end else if (!pend[n] && $urandom_range(0, 3) == 0) begin
            rq[n] = 1; pend[n] = 1; gseen[n] = 0;
            rdd[n] = 8'($urandom);
            rdq[n] = ($urandom_range(0, 7) == 0) ? 4'd0 : 4'($urandom_range(1, 15));
          end else if (rq[n] && gseen[n] && $urandom_range(0, 19) == 0) begin
            rq[n] = 0;
          end
        end
      end
      bus.req0 = rq[0]; bus.dd0 = rdd[0]; bus.dq0 = rdq[0];
      bus.req1 = rq[1]; bus.dd1 = rdd[1]; bus.dq1 = rdq[1];
    end
    bus.req0 = 0; bus.req1 = 0; rst = 0;
    repeat (LAT + 6) @(negedge clk);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
